// File: rtl/pes_intr_cntrl.sv
// pes_intr_cntrl: 8-source interrupt controller with round-robin (polling) or
// programmable fixed-priority arbitration, vector/EOI handshake on a shared bus.
module pes_intr_cntrl (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] intr_rq,
    inout  wire  [7:0] intr_bus,
    input  logic       intr_in,
    output logic       intr_out,
    output logic       bus_oe
);

    typedef enum logic [2:0] {
        S_CFG   = 3'd0,
        S_PLOAD = 3'd1,
        S_IDLE  = 3'd2,
        S_REQ   = 3'd3,
        S_VEC   = 3'd4,
        S_ISR   = 3'd5
    } state_t;

    state_t           r_state, w_nxt_state;
    logic             r_prio_mode;   // 0 = polling, 1 = priority
    logic [7:0][2:0]  r_prio;        // slot -> source id, slot 0 highest
    logic [1:0]       r_pidx;        // next slot pair to load in PLOAD
    logic [2:0]       r_ptr;         // polling scan start
    logic [2:0]       r_id;          // source currently in service

    logic             w_poll_hit, w_prio_hit, w_hit;
    logic [2:0]       w_poll_id, w_prio_id, w_sel_id;
    logic [7:0]       w_vec, w_eoi;

    // Outputs decode straight from the state register, so reset clears them at once
    assign intr_out = (r_state == S_REQ);
    assign bus_oe   = (r_state == S_VEC);
    assign intr_bus = bus_oe ? w_vec : 8'bz;

    assign w_vec = r_prio_mode ? {5'b10011, r_id} : {5'b01011, r_id};
    assign w_eoi = r_prio_mode ? {5'b01100, r_id} : {5'b10100, r_id};

    // Round-robin scan: first requesting source at or above the pointer, wrapping
    always_comb begin
        w_poll_hit = 1'b0;
        w_poll_id  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (intr_rq[r_ptr + 3'(k)]) begin
                w_poll_hit = 1'b1;
                w_poll_id  = r_ptr + 3'(k);
            end
        end
    end

    // Fixed priority: lowest slot whose programmed id is requesting
    always_comb begin
        w_prio_hit = 1'b0;
        w_prio_id  = 3'd0;
        for (int s = 7; s >= 0; s--) begin
            if (intr_rq[r_prio[s]]) begin
                w_prio_hit = 1'b1;
                w_prio_id  = r_prio[s];
            end
        end
    end

    assign w_hit    = r_prio_mode ? w_prio_hit : w_poll_hit;
    assign w_sel_id = r_prio_mode ? w_prio_id  : w_poll_id;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_CFG;
        else         r_state <= w_nxt_state;
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_CFG: begin
                if (intr_bus[1:0] == 2'b01)      w_nxt_state = S_IDLE;
                else if (intr_bus[1:0] == 2'b10) w_nxt_state = S_PLOAD;
            end
            S_PLOAD: if (intr_bus[1:0] == 2'b10 && r_pidx == 2'd3) w_nxt_state = S_IDLE;
            S_IDLE:  if (w_hit)                                  w_nxt_state = S_REQ;
            S_REQ:   if (!intr_in)                               w_nxt_state = S_VEC;
            S_VEC:   if (!intr_in)                               w_nxt_state = S_ISR;
            S_ISR:   if (!intr_in && intr_bus == w_eoi)          w_nxt_state = S_IDLE;
            default:                                             w_nxt_state = S_CFG;
        endcase
    end

    // Configuration capture, id latch and polling pointer advance
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_prio_mode <= 1'b0;
            r_prio      <= '0;
            r_pidx      <= 2'd1;
            r_ptr       <= 3'd0;
            r_id        <= 3'd0;
        end else begin
            case (r_state)
                S_CFG: begin
                    if (intr_bus[1:0] == 2'b01) begin
                        r_prio_mode <= 1'b0;
                    end else if (intr_bus[1:0] == 2'b10) begin
                        r_prio_mode <= 1'b1;
                        r_prio[0]   <= intr_bus[7:5];
                        r_prio[1]   <= intr_bus[4:2];
                        r_pidx      <= 2'd1;
                    end
                end
                S_PLOAD: begin
                    if (intr_bus[1:0] == 2'b10) begin
                        r_prio[{r_pidx, 1'b0}] <= intr_bus[7:5];
                        r_prio[{r_pidx, 1'b1}] <= intr_bus[4:2];
                        r_pidx                 <= r_pidx + 2'd1;
                    end
                end
                S_IDLE: if (w_hit) r_id <= w_sel_id;
                S_ISR:  if (!intr_in && intr_bus == w_eoi) r_ptr <= r_id + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pes_intr_cntrl.sv
// Directed bench for pes_intr_cntrl: polling round-robin, programmed priority,
// bad EOI rejection and reset during vector phase.
module tb_pes_intr_cntrl;

    logic       clk_in, rst_in, intr_in;
    logic [7:0] intr_rq;
    wire  [7:0] intr_bus;
    wire        intr_out, bus_oe;
    logic       tb_oe;
    logic [7:0] tb_bus;

    int n_vec = 0;
    int n_err = 0;

    assign intr_bus = tb_oe ? tb_bus : 8'bz;

    pes_intr_cntrl dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .intr_rq  (intr_rq),
        .intr_bus (intr_bus),
        .intr_in  (intr_in),
        .intr_out (intr_out),
        .bus_oe   (bus_oe)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        tb_oe  = 1'b1;
        tb_bus = b;
        @(negedge clk_in);
        tb_oe  = 1'b0;
    endtask

    task automatic do_reset();
        rst_in  = 1'b0;
        tb_oe   = 1'b0;
        intr_in = 1'b1;
        intr_rq = 8'h00;
        repeat (2) @(negedge clk_in);
        chk("rst_intr_out", {7'd0, intr_out}, 8'd0);
        chk("rst_bus_oe",   {7'd0, bus_oe},   8'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    // Wait (bounded) for intr_out, then two acks: vector check, bus release check
    task automatic svc_part(input logic [2:0] id, input logic prio);
        int n = 0;
        while (intr_out !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk("req_rise", {7'd0, intr_out}, 8'd1);
        intr_in = 1'b0;
        @(negedge clk_in);
        intr_in = 1'b1;
        chk("vec_byte",   intr_bus, prio ? {5'b10011, id} : {5'b01011, id});
        chk("vec_oe",     {7'd0, bus_oe},   8'd1);
        chk("vec_intout", {7'd0, intr_out}, 8'd0);
        intr_in = 1'b0;
        @(negedge clk_in);
        intr_in = 1'b1;
        chk("ack2_oe", {7'd0, bus_oe}, 8'd0);
    endtask

    task automatic eoi(input logic [2:0] id, input logic prio);
        tb_oe   = 1'b1;
        tb_bus  = prio ? {5'b01100, id} : {5'b10100, id};
        intr_in = 1'b0;
        @(negedge clk_in);
        intr_in = 1'b1;
        tb_oe   = 1'b0;
        chk("eoi_intout", {7'd0, intr_out}, 8'd0);
    endtask

    // Priority service: peripheral drops its line after the vector, others may rise
    task automatic psvc(input logic [2:0] id, input logic [7:0] set_mask);
        svc_part(id, 1'b1);
        intr_rq     = intr_rq | set_mask;
        intr_rq[id] = 1'b0;
        eoi(id, 1'b1);
    endtask

    initial begin
        logic [2:0] pids [11];
        logic [7:0] pset [11];
        pids = '{3'd5, 3'd3, 3'd7, 3'd0, 3'd4, 3'd3, 3'd2, 3'd5, 3'd6, 3'd1, 3'd0};
        pset = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        tb_bus = 8'h00;

        // ---- polling mode ----
        do_reset();
        wr(8'h01);
        intr_rq = 8'b1010_1010;
        for (int i = 0; i < 4; i++) begin
            svc_part(3'(2*i+1), 1'b0);
            if (i == 3) intr_rq = 8'b0101_0101;
            eoi(3'(2*i+1), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            svc_part(3'(2*i), 1'b0);
            eoi(3'(2*i), 1'b0);
        end

        // wrong EOI (priority-style byte in polling mode) must be ignored
        svc_part(3'd0, 1'b0);
        tb_oe   = 1'b1;
        tb_bus  = 8'h60;
        intr_in = 1'b0;
        @(negedge clk_in);
        intr_in = 1'b1;
        tb_oe   = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("bad_eoi_intout", {7'd0, intr_out}, 8'd0);
        chk("bad_eoi_oe",     {7'd0, bus_oe},   8'd0);
        eoi(3'd0, 1'b0);
        svc_part(3'd2, 1'b0);
        eoi(3'd2, 1'b0);

        // ---- priority mode: table 5,3,7,0,4,2,6,1 ----
        do_reset();
        wr(8'hAE);
        wr(8'hE2);
        wr(8'h8A);
        wr(8'hC6);
        intr_rq = 8'hFF;
        for (int i = 0; i < 10; i++) psvc(pids[i], pset[i]);
        chk("prio_drained_rq", intr_rq, 8'h00);

        // ---- reset while the vector is on the bus ----
        do_reset();
        wr(8'h01);
        intr_rq = 8'h08;
        begin
            int n = 0;
            while (intr_out !== 1'b1 && n < 20) begin
                @(negedge clk_in);
                n++;
            end
        end
        chk("rv_req", {7'd0, intr_out}, 8'd1);
        intr_in = 1'b0;
        @(negedge clk_in);
        intr_in = 1'b1;
        chk("rv_vec_oe", {7'd0, bus_oe}, 8'd1);
        #2 rst_in = 1'b0;
        #1;
        chk("rv_async_oe",     {7'd0, bus_oe},   8'd0);
        chk("rv_async_intout", {7'd0, intr_out}, 8'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tb_oe  = 1'b1;
        tb_bus = 8'h00;
        repeat (5) @(negedge clk_in);
        chk("rv_cfg_ignore", {7'd0, intr_out}, 8'd0);
        wr(8'h01);
        svc_part(3'd3, 1'b0);
        eoi(3'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
